nios2_gpio_pio: RTL and testbench

- Parametrised Avalon-MM slave GPIO for the Nios II system; successor to the fixed 8-bit output-only LED PIO.
- Each bit is individually an input or an output, set through a direction register.
- Inputs are synchronised, edge-captured and can raise a maskable level interrupt to the CPU.
- Sits on the CPU data master alongside the other PIO slaves, one instance per board I/O group (LEDs, keys, switches, headers).

---
 rtl/nios2_gpio_pio.sv | 135 +++++++++++++
 tb/tb_nios2_gpio_pio.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nios2_gpio_pio.sv
// nios2_gpio_pio: parametrised Avalon-MM GPIO slave with per-bit direction,
// synchronised inputs, edge capture and a maskable level interrupt.
// Optional: define GPIO_PIO_OUTSETCLR_EN for atomic outset (@4) / outclear (@5).
// Reads are zero-wait combinational; writes land on the sampling edge.
module nios2_gpio_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  // warm-up runs for one cycle more than the synchroniser depth so the
  // first valid prev/sync_in pair is seen before capture is allowed
  localparam logic [2:0] WU_MAX = 3'(SYNC_STAGES + 1);

  logic                                wr;
  logic [WIDTH-1:0]                    wdata;
  logic                                unused_wdata;

  logic [WIDTH-1:0]                    data_out_q, data_out_d;
  logic [WIDTH-1:0]                    dir_q, dir_d;
  logic [WIDTH-1:0]                    irqmask_q, irqmask_d;
  logic [WIDTH-1:0]                    edgecap_q, edgecap_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    prev_q;
  logic [WIDTH-1:0]                    sync_in;
  logic [2:0]                          wu_q, wu_d;
  logic                                wu_done;
  logic                                irq_q, irq_d;
  logic [WIDTH-1:0]                    edge_hit;
  logic [WIDTH-1:0]                    rd_val;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  // upper writedata bits are intentionally dropped for narrow instances
  assign unused_wdata = &{1'b0, writedata};
  assign sync_in      = sync_q[SYNC_STAGES-1];
  assign wu_done      = (wu_q == WU_MAX);

  // input synchroniser chain plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_in;
    end
  end

  // edge selection fixed at elaboration by EDGE_TYPE
  always_comb begin
    edge_hit = sync_in & ~prev_q;
    case (EDGE_TYPE)
      1:       edge_hit = ~sync_in & prev_q;
      2:       edge_hit = sync_in ^ prev_q;
      default: edge_hit = sync_in & ~prev_q;
    endcase
  end

  // next-state for software-visible registers, warm-up counter and irq
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    edgecap_d  = edgecap_q;
    wu_d       = wu_done ? wu_q : wu_q + 3'd1;
    irq_d      = |(edgecap_q & irqmask_q);
    if (wr) begin
      case (address)
        3'd0: data_out_d = wdata;
        3'd1: dir_d      = wdata;
        3'd2: irqmask_d  = wdata;
        3'd3: edgecap_d  = edgecap_q & ~wdata;
`ifdef GPIO_PIO_OUTSETCLR_EN
        3'd4: data_out_d = data_out_q | wdata;
        3'd5: data_out_d = data_out_q & ~wdata;
`endif
        default: ;
      endcase
    end
    // new edges are ORed in after the clear so a coincident set wins
    if (wu_done) edgecap_d = edgecap_d | (edge_hit & ~dir_q);
  end

  // register state; everything returns to reset values asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      wu_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      wu_q       <= wu_d;
      irq_q      <= irq_d;
    end
  end

  // zero-wait read mux, no side effects; unused addresses read zero
  always_comb begin
    rd_val = '0;
    case (address)
      3'd0:    rd_val = (sync_in & ~dir_q) | (data_out_q & dir_q);
      3'd1:    rd_val = dir_q;
      3'd2:    rd_val = irqmask_q;
      3'd3:    rd_val = edgecap_q;
      default: rd_val = '0;
    endcase
  end

  assign readdata = 32'(rd_val);
  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_gpio_pio.sv
// Directed-vector bench for nios2_gpio_pio (WIDTH 8, RESET_VALUE A5, rising edges).
module tb_nios2_gpio_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe_port;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] r;

  nios2_gpio_pio #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_out", {24'd0, out_port}, 32'hA5);
    chk("rst_oe", {24'd0, oe_port}, 32'h00);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(3'd1, r); chk("rst_rd1", r, 32'h0);
    rd(3'd2, r); chk("rst_rd2", r, 32'h0);
    rd(3'd3, r); chk("rst_rd3", r, 32'h0);

    // pins high through reset release must not look like edges
    repeat (6) tick();
    rd(3'd3, r); chk("warmup_ec", r, 32'h0);

    wr(3'd1, 32'hFF);
    rd(3'd0, r); chk("dir_ff_rd0", r, 32'hA5);
    chk("dir_ff_oe", {24'd0, oe_port}, 32'hFF);

    // quiet inputs, arm bit 0
    in_port = 8'h00;
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h01);
    repeat (3) tick();
    wr(3'd3, 32'hFF);

    // latency of a rising edge on bit 0
    in_port = 8'h01;
    tick();
    rd(3'd0, r); chk("lat_e1_rd0", r, 32'h00);
    tick();
    rd(3'd0, r); chk("lat_e2_rd0", r, 32'h01);
    rd(3'd3, r); chk("lat_e2_ec", r, 32'h00);
    tick();
    rd(3'd3, r); chk("lat_e3_ec", r, 32'h01);
    chk("lat_e3_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("lat_e4_irq", {31'd0, irq}, 32'd1);

    // clear drops irq one edge later
    wr(3'd3, 32'h01);
    rd(3'd3, r); chk("clr_ec", r, 32'h00);
    chk("clr_n_irq", {31'd0, irq}, 32'd1);
    tick();
    chk("clr_n1_irq", {31'd0, irq}, 32'd0);

    // capture bit 0 again
    in_port = 8'h00;
    repeat (3) tick();
    in_port = 8'h01;
    repeat (3) tick();
    rd(3'd3, r); chk("recap_ec", r, 32'h01);
    tick();
    chk("recap_irq", {31'd0, irq}, 32'd1);

    // clear write lands on the same edge as a new capture: set wins
    in_port = 8'h00;
    repeat (3) tick();
    in_port = 8'h01;
    repeat (2) tick();
    wr(3'd3, 32'h01);
    rd(3'd3, r); chk("setwin_ec", r, 32'h01);
    chk("setwin_irq", {31'd0, irq}, 32'd1);
    tick();
    chk("setwin_irq2", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'hFF);
    tick();
    chk("cleanup_irq", {31'd0, irq}, 32'd0);

    // mixed direction read-back
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'hFF);
    in_port = 8'h3C;
    repeat (3) tick();
    rd(3'd0, r); chk("mix_rd0", r, 32'h3F);
    chk("mix_oe", {24'd0, oe_port}, 32'h0F);
    rd(3'd3, r); chk("mix_ec", r, 32'h30);
    wr(3'd1, 32'h00);
    rd(3'd3, r); chk("dirclr_ec", r, 32'h30);
    rd(3'd0, r); chk("dirclr_rd0", r, 32'h3C);
    chk("dirclr_out", {24'd0, out_port}, 32'hFF);

    // upper writedata bits ignored; mask enables captured bits
    wr(3'd2, 32'h0000_1230);
    rd(3'd2, r); chk("wide_mask", r, 32'h30);
    tick();
    chk("mask_irq", {31'd0, irq}, 32'd1);

    // outset/outclear and reserved addresses
    wr(3'd0, 32'h00);
    wr(3'd4, 32'h81);
`ifdef GPIO_PIO_OUTSETCLR_EN
    chk("outset", {24'd0, out_port}, 32'h81);
`else
    chk("outset", {24'd0, out_port}, 32'h00);
`endif
    wr(3'd5, 32'h01);
`ifdef GPIO_PIO_OUTSETCLR_EN
    chk("outclr", {24'd0, out_port}, 32'h80);
`else
    chk("outclr", {24'd0, out_port}, 32'h00);
`endif
    rd(3'd4, r); chk("rd4", r, 32'h0);
    rd(3'd5, r); chk("rd5", r, 32'h0);
    wr(3'd6, 32'hFF);
    wr(3'd7, 32'hFF);
    rd(3'd6, r); chk("rd6", r, 32'h0);
    rd(3'd7, r); chk("rd7", r, 32'h0);
`ifdef GPIO_PIO_OUTSETCLR_EN
    chk("rsvd_out", {24'd0, out_port}, 32'h80);
`else
    chk("rsvd_out", {24'd0, out_port}, 32'h00);
`endif

    // asynchronous reset mid-operation
    reset = 1'b1;
    #1;
    chk("arst_out", {24'd0, out_port}, 32'hA5);
    chk("arst_oe", {24'd0, oe_port}, 32'h00);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    rd(3'd3, r); chk("arst_ec", r, 32'h0);
    rd(3'd2, r); chk("arst_mask", r, 32'h0);
    tick();
    reset = 1'b0;
    // warm-up restarts: pins at 3C must not capture after release
    repeat (6) tick();
    rd(3'd3, r); chk("rewarm_ec", r, 32'h0);
    rd(3'd0, r); chk("rewarm_rd0", r, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
